// File: rtl/divider.sv
// divider: 32-bit signed/unsigned divide and remainder, one restoring radix-2 step per cycle.
// Divide-by-zero and signed overflow skip the iteration and produce their result immediately.
module divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [31:0] result_q, result_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_q, neg_d;

    logic        sgn, a_neg, b_neg, div_zero, ovf;
    logic [31:0] mag_a, mag_b, rem_nxt, quo_nxt, raw;
    logic [32:0] shifted, diff;

    assign sgn      = ~op[0];
    assign a_neg    = sgn & dividend[31];
    assign b_neg    = sgn & divisor[31];
    assign mag_a    = a_neg ? -dividend : dividend;
    assign mag_b    = b_neg ? -divisor : divisor;
    assign div_zero = divisor == 32'd0;
    assign ovf      = sgn & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);

    // Trial subtract: a borrow out of bit 32 means the divisor did not fit, so keep the shifted value.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, div_q};
    assign rem_nxt  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nxt  = {quo_q[30:0], ~diff[32]};
    assign raw      = is_rem_q ? rem_nxt : quo_nxt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: if (valid) begin
                if (div_zero || ovf) begin
                    state_d  = DONE;
                    result_d = div_zero ? (op[1] ? dividend : 32'hFFFF_FFFF)
                                        : (op[1] ? 32'd0 : 32'h8000_0000);
                end else begin
                    state_d  = CALC;
                    cnt_d    = 6'd0;
                    rem_d    = 32'd0;
                    quo_d    = mag_a;
                    div_d    = mag_b;
                    is_rem_d = op[1];
                    neg_d    = op[1] ? a_neg : a_neg ^ b_neg;
                end
            end
            CALC: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d  = DONE;
                    result_d = neg_q ? -raw : raw;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            div_q    <= 32'd0;
            result_q <= 32'd0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            result_q <= result_d;
            is_rem_q <= is_rem_d;
            neg_q    <= neg_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign ready  = state_q == DONE;
    assign result = result_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed divide/remainder vectors with hand-computed results and ready latency.
module tb_divider;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, ready;
    logic [31:0] result;
    int errors = 0;
    int checks = 0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    divider dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // pulse_at: cycle at which a second request is pushed in; abort_at: cycle at which reset is pulled.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp, input int pulse_at, input int abort_at);
        int c;
        logic busy_ok;
        logic late_ready;
        @(negedge clk);
        op = o; dividend = a; divisor = b; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        busy_ok = 1'b1;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready) break;
            if (!busy) busy_ok = 1'b0;
            if (c == pulse_at) begin
                op = DIVU; dividend = a + 32'd1234; divisor = 32'd1; valid = 1'b1;
            end else valid = 1'b0;
            if (c == abort_at) begin
                resetn = 1'b0;
                #1;
                chk({tag, " abort busy"}, {31'd0, busy}, 32'd0);
                chk({tag, " abort ready"}, {31'd0, ready}, 32'd0);
                chk({tag, " abort result"}, result, 32'd0);
                late_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    late_ready |= ready;
                end
                resetn = 1'b1;
                repeat (40) begin
                    @(negedge clk);
                    late_ready |= ready;
                end
                chk({tag, " no ready after abort"}, {31'd0, late_ready}, 32'd0);
                return;
            end
        end
        valid = 1'b0;
        chk({tag, " latency"}, c, lat);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy until ready"}, {31'd0, busy_ok & busy}, 32'd1);
        @(negedge clk);
        chk({tag, " ready one cycle"}, {30'd0, ready, busy}, 32'd0);
        chk({tag, " result hold"}, result, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset result", result, 32'd0);
        resetn = 1'b1;
        run("divu 100/7", DIVU, 32'd100, 32'd7, 33, 32'd14, 0, 0);
        run("remu 100/7", REMU, 32'd100, 32'd7, 33, 32'd2, 0, 0);
        run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 0, 0);
        run("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 0, 0);
        run("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 0, 0);
        run("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 0, 0);
        run("div 5/0", DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 0, 0);
        run("remu 5/0", REMU, 32'd5, 32'd0, 1, 32'd5, 0, 0);
        run("divu max/1", DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 0, 0);
        run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0);
        run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0, 0);
        run("divu 0x80000000/-1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 0, 0);
        run("remu big", REMU, 32'hDEAD_BEEF, 32'h0001_0000, 33, 32'h0000_BEEF, 0, 0);
        run("divu pulse ignored", DIVU, 32'd100, 32'd7, 33, 32'd14, 10, 0);
        run("abort", DIVU, 32'd1000, 32'd7, 33, 32'd142, 0, 15);
        run("divu 9/3", DIVU, 32'd9, 32'd3, 33, 32'd3, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
